// File: rtl/cic_int_up_if.sv
// Sample stream between the compensation interpolator, the CIC interpolator and the DAC/NCO path.
interface cic_int_up_if #(
    parameter int unsigned DW = 16
);
    logic          in_valid;
    logic [DW-1:0] filter_in;
    logic          in_ready;
    logic [DW-1:0] filter_out;
    logic          ce_out;

    modport master (
        output in_valid, filter_in,
        input  in_ready, filter_out, ce_out
    );

    modport slave (
        input  in_valid, filter_in,
        output in_ready, filter_out, ce_out
    );
endinterface

// File: rtl/cic_int_up.sv
// N-stage CIC interpolator by 2**RATE_LOG2 behind a one-entry holding register;
// output is rounded half-up, shifted by the CIC gain and saturated to DW bits.
module cic_int_up #(
    parameter int unsigned DW        = 16,
    parameter int unsigned N         = 3,
    parameter int unsigned RATE_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        clear_flags,
    output logic        underrun,
    output logic        overrun,
    cic_int_up_if.slave bus
);
    localparam int unsigned W     = DW + N * RATE_LOG2;
    localparam int unsigned SHIFT = (N - 1) * RATE_LOG2;

    localparam logic [W:0] RND     = ((W + 1)'(1) << SHIFT) >> 1;
    localparam logic [W:0] SAT_MAX = {{(W + 2 - DW){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic [W:0] SAT_MIN = ~SAT_MAX;

    logic [RATE_LOG2-1:0] phase_q, phase_d;
    logic [DW-1:0]        hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 armed_q, armed_d;
    logic [W-1:0]         dly_q [N];
    logic [W-1:0]         dly_d [N];
    logic [W-1:0]         comb_out_q, comb_out_d;
    logic                 comb_fresh_q, comb_fresh_d;
    logic [W-1:0]         integ_q [N];
    logic [W-1:0]         integ_d [N];
    logic [DW-1:0]        filter_out_q, filter_out_d;
    logic                 ce_out_q, ce_out_d;
    logic                 underrun_q, underrun_d;
    logic                 overrun_q, overrun_d;

    logic                 consume;
    logic [W-1:0]         comb_acc;
    logic [W:0]           rnd_sum;
    logic [W:0]           scaled;

    // Next-state logic for holding register, comb, integrators and output stage.
    always_comb begin
        phase_d      = phase_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        armed_d      = armed_q;
        dly_d        = dly_q;
        comb_out_d   = comb_out_q;
        comb_fresh_d = comb_fresh_q;
        integ_d      = integ_q;
        filter_out_d = filter_out_q;
        ce_out_d     = clk_enable;
        comb_acc     = '0;

        consume = clk_enable && (phase_q == '0);

        if (clk_enable) begin
            phase_d = phase_q + RATE_LOG2'(1);
        end

        if (bus.in_valid) begin
            hold_d      = bus.filter_in;
            hold_full_d = 1'b1;
            armed_d     = 1'b1;
        end else if (consume) begin
            hold_full_d = 1'b0;
        end

        // Clear loses to a same-cycle set.
        underrun_d = (underrun_q & ~clear_flags) | (consume & ~hold_full_q & armed_q);
        overrun_d  = (overrun_q & ~clear_flags) | (bus.in_valid & hold_full_q & ~consume);

        // An empty register feeds a zero sample into the comb.
        if (hold_full_q) begin
            comb_acc = {{(W - DW){hold_q[DW-1]}}, hold_q};
        end
        if (consume) begin
            for (int unsigned k = 0; k < N; k++) begin
                dly_d[k] = comb_acc;
                comb_acc = comb_acc - dly_q[k];
            end
            comb_out_d   = comb_acc;
            comb_fresh_d = 1'b1;
        end else if (clk_enable) begin
            comb_fresh_d = 1'b0;
        end

        rnd_sum = {integ_q[N-1][W-1], integ_q[N-1]} + RND;
        scaled  = (W + 1)'($signed(rnd_sum) >>> SHIFT);

        if (clk_enable) begin
            integ_d[0] = integ_q[0] + (comb_fresh_q ? comb_out_q : '0);
            for (int unsigned k = 1; k < N; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            if ($signed(scaled) > $signed(SAT_MAX)) begin
                filter_out_d = {1'b0, {(DW - 1){1'b1}}};
            end else if ($signed(scaled) < $signed(SAT_MIN)) begin
                filter_out_d = {1'b1, {(DW - 1){1'b0}}};
            end else begin
                filter_out_d = scaled[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            armed_q      <= 1'b0;
            comb_out_q   <= '0;
            comb_fresh_q <= 1'b0;
            filter_out_q <= '0;
            ce_out_q     <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                dly_q[k]   <= '0;
                integ_q[k] <= '0;
            end
        end else begin
            phase_q      <= phase_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            armed_q      <= armed_d;
            comb_out_q   <= comb_out_d;
            comb_fresh_q <= comb_fresh_d;
            filter_out_q <= filter_out_d;
            ce_out_q     <= ce_out_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
            dly_q        <= dly_d;
            integ_q      <= integ_d;
        end
    end

    assign underrun       = underrun_q;
    assign overrun        = overrun_q;
    assign bus.in_ready   = ~hold_full_q;
    assign bus.filter_out = filter_out_q;
    assign bus.ce_out     = ce_out_q;
endmodule

// File: tb/tb_cic_int_up.sv
// Bench for cic_int_up: per-cycle comparison against an equivalent-FIR model of the
// zero-stuffed input stream, plus hand-computed expectations for key scenarios.
module tb_cic_int_up;
    localparam int DW    = 16;
    localparam int N     = 3;
    localparam int RL    = 3;
    localparam int R     = 8;
    localparam int SHIFT = 6;
    localparam int HL    = N * (R - 1) + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clk_enable = 1'b0;
    logic clear_flags = 1'b0;
    logic underrun, overrun;

    cic_int_up_if #(.DW(DW)) bus ();

    cic_int_up #(.DW(DW), .N(N), .RATE_LOG2(RL)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .clear_flags(clear_flags),
        .underrun   (underrun),
        .overrun    (overrun),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    longint rec[$];

    // Reference: the CIC is the FIR (box of length R)^N applied to the zero-stuffed tick stream.
    longint h[HL];
    longint u_hist[$];
    int     m_tick;
    bit     m_full, m_armed, m_ur, m_or, e_ce, m_c, m_su, m_so;
    longint m_hold, m_x, e_out;

    function automatic void build_h();
        longint t[HL];
        for (int i = 0; i < HL; i++) h[i] = (i < R) ? 1 : 0;
        for (int s = 1; s < N; s++) begin
            t = h;
            for (int i = 0; i < HL; i++) begin
                h[i] = 0;
                for (int k = 0; k < R; k++) if (i - k >= 0) h[i] += t[i-k];
            end
        end
    endfunction

    function automatic longint exp_y(int t);
        longint acc = 0;
        for (int j = 0; j < HL; j++) begin
            int idx = t - (N + 1) - j;
            if (idx >= 0) acc += h[j] * u_hist[idx];
        end
        acc = (acc + 32) >>> SHIFT;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_tick = 0; u_hist.delete();
            m_full = 0; m_armed = 0; m_ur = 0; m_or = 0;
            m_hold = 0; e_out = 0; e_ce = 0;
        end else begin
            m_c = clk_enable && (m_tick % R == 0);
            m_x = 0; m_su = 0; m_so = 0;
            if (m_c) begin
                if (m_full) m_x = m_hold;
                else if (m_armed) m_su = 1;
            end
            if (bus.in_valid && m_full && !m_c) m_so = 1;
            if (bus.in_valid) begin
                m_hold = longint'($signed(bus.filter_in)); m_full = 1; m_armed = 1;
            end else if (m_c) m_full = 0;
            m_ur = (m_ur && !clear_flags) || m_su;
            m_or = (m_or && !clear_flags) || m_so;
            e_ce = clk_enable;
            if (clk_enable) begin
                u_hist.push_back(m_x);
                e_out = exp_y(m_tick);
                m_tick++;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        chk("filter_out", longint'($signed(bus.filter_out)), e_out);
        chk("ce_out", longint'(bus.ce_out), longint'(e_ce));
        chk("in_ready", longint'(bus.in_ready), longint'(!m_full));
        chk("underrun", longint'(underrun), longint'(m_ur));
        chk("overrun", longint'(overrun), longint'(m_or));
        if (bus.ce_out) rec.push_back(longint'($signed(bus.filter_out)));
    endtask

    task automatic cyc(input bit ce, input bit iv, input longint din, input bit clr);
        @(posedge clk); #1;
        clk_enable = ce; bus.in_valid = iv; bus.filter_in = DW'(din); clear_flags = clr;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle_tick();
        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
    endtask

    // One input sample: pushed ahead of its phase-0 tick, then R-1 further ticks.
    task automatic feed(input longint v);
        cyc(0, 1, v, 0);
        repeat (2) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (R - 1) idle_tick();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1; clk_enable = 0; bus.in_valid = 0; bus.filter_in = '0; clear_flags = 0;
        #1;
        chk("rst_filter_out", longint'($signed(bus.filter_out)), 0);
        chk("rst_ce_out", longint'(bus.ce_out), 0);
        chk("rst_in_ready", longint'(bus.in_ready), 1);
        chk("rst_flags", longint'({underrun, overrun}), 0);
        @(posedge clk); #1;
        reset = 0;
        rec.delete();
    endtask

    task automatic random_run(input int cycles);
        bit ce, iv, clr, pce;
        logic [15:0] rv;
        pce = 0;
        for (int c = 0; c < cycles; c++) begin
            ce  = !pce && ($urandom_range(0, 2) == 0);
            iv  = ($urandom_range(0, 19) == 0);
            clr = ($urandom_range(0, 99) == 0);
            rv  = 16'($urandom);
            cyc(ce, iv, longint'($signed(rv)), clr);
            pce = ce;
        end
    endtask

    initial begin
        longint sum, peak, acc;
        int first, nz, viol;
        logic [15:0] rv;
        bus.in_valid = 0; bus.filter_in = '0;
        build_h();

        // Idle after reset: no samples, no underrun.
        do_reset();
        repeat (64) idle_tick();
        cyc(0, 0, 0, 0);
        chk("idle_ce_count", rec.size(), 64);
        acc = 0;
        foreach (rec[i]) acc += (rec[i] < 0) ? -rec[i] : rec[i];
        chk("idle_all_zero", acc, 0);
        chk("idle_underrun", longint'(underrun), 0);

        // DC input of 1000.
        do_reset();
        repeat (8) feed(1000);
        cyc(0, 0, 0, 0);
        chk("dc_tick3", rec[3], 0);
        chk("dc_tick4", rec[4], 16);
        chk("dc_tick28", rec[28], 1000);
        chk("dc_final", rec[63], 1000);
        viol = 0;
        for (int i = 1; i < 64; i++) if (rec[i] < rec[i-1]) viol++;
        chk("dc_monotonic", viol, 0);
        chk("dc_flags", longint'({underrun, overrun}), 0);

        // Impulse of 8192.
        do_reset();
        feed(8192);
        repeat (4) feed(0);
        cyc(0, 0, 0, 0);
        sum = 0; peak = 0; first = -1; nz = 0;
        foreach (rec[i]) begin
            sum += rec[i];
            if (rec[i] > peak) peak = rec[i];
            if (rec[i] != 0) begin nz++; if (first < 0) first = i; end
        end
        chk("imp_first", first, 4);
        chk("imp_count", nz, 22);
        chk("imp_sum", sum, 65536);
        chk("imp_peak", peak, 6144);
        viol = 0;
        for (int k = 0; k < 22; k++) if (rec[4+k] != rec[25-k]) viol++;
        chk("imp_symmetry", viol, 0);

        // Full-scale steps.
        do_reset();
        repeat (64) feed(32767);
        chk("step_hi", longint'($signed(bus.filter_out)), 32767);
        repeat (64) feed(-32768);
        cyc(0, 0, 0, 0);
        chk("step_lo", longint'($signed(bus.filter_out)), -32768);
        viol = 0;
        for (int i = 1; i < 512; i++) if (rec[i] < rec[i-1]) viol++;
        for (int i = 513; i < 1024; i++) if (rec[i] > rec[i-1]) viol++;
        chk("step_no_glitch", viol, 0);

        // Overrun, underrun, clear, and clear losing to a same-cycle set.
        do_reset();
        cyc(0, 1, 111, 0);
        cyc(0, 1, 222, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("overrun_set", longint'(overrun), 1);
        repeat (R) idle_tick();
        repeat (2) cyc(0, 0, 0, 0);
        chk("underrun_set", longint'(underrun), 1);
        chk("ovr_second_used", rec[4], 3);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("flags_cleared", longint'({underrun, overrun}), 0);
        cyc(0, 1, 5, 0);
        cyc(0, 1, 6, 1);
        repeat (2) cyc(0, 0, 0, 0);
        chk("clr_vs_set", longint'(overrun), 1);

        // Load on the same clk as a consume, then mid-stream reset.
        do_reset();
        cyc(0, 1, 300, 0);
        repeat (2) cyc(0, 0, 0, 0);
        cyc(1, 1, 400, 0);
        cyc(0, 0, 0, 0);
        chk("same_clk_no_ovr", longint'(overrun), 0);
        chk("same_clk_full", longint'(bus.in_ready), 0);
        repeat (R) idle_tick();
        repeat (R) idle_tick();
        chk("same_clk_t4", rec[4], 5);
        chk("same_clk_t12", rec[12], 203);
        repeat (5) feed(-12000);
        do_reset();
        repeat (R) idle_tick();
        repeat (2) cyc(0, 0, 0, 0);
        chk("post_reset_underrun", longint'(underrun), 0);

        // Random samples in the normal flow, then fully random control.
        do_reset();
        for (int s = 0; s < 40; s++) begin
            rv = 16'($urandom);
            feed(longint'($signed(rv)));
        end
        random_run(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
